// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
//  Module   : vend_controller
//  Brief    : Vending machine controller. Accepts coin, select and cancel keys
//             from the keypad scanner, accumulates credit up to a ceiling,
//             dispenses a product for a fixed hold time, then returns change.
//  Revision : 1.0 - initial release
// ============================================================================
module vend_controller #(
  parameter int PRICE_A         = 25,
  parameter int PRICE_B         = 50,
  parameter int PRICE_C         = 75,
  parameter int PRICE_D         = 100,
  parameter int MAX_CREDIT      = 250,
  parameter int DISPENSE_CYCLES = 4,
  parameter int CHANGE_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_value,
  input  logic       key_valid,
  output logic [7:0] credit,
  output logic [7:0] change,
  output logic [1:0] product,
  output logic       dispense,
  output logic       change_valid,
  output logic       busy,
  output logic       coin_reject,
  output logic       insufficient
);

  // One shared hold counter serves both VEND and CHANGE; size it for the longer
  localparam int CNT_MAX = (DISPENSE_CYCLES > CHANGE_CYCLES) ? DISPENSE_CYCLES : CHANGE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISPENSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHG_LAST  = CNT_W'(CHANGE_CYCLES - 1);
  localparam logic [8:0]       CEILING   = 9'(MAX_CREDIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       credit_q, credit_d;
  logic [7:0]       change_q, change_d;
  logic [1:0]       product_q, product_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dispense_q, dispense_d;
  logic             change_valid_q, change_valid_d;
  logic             busy_q, busy_d;
  logic             coin_reject_q, coin_reject_d;
  logic             insufficient_q, insufficient_d;

  logic             is_coin, is_sel, is_cancel;
  logic [7:0]       coin_val, sel_price;
  logic [1:0]       sel_prod;
  logic [8:0]       credit_sum;
  logic             coin_ok, price_ok;

  // Decode the key code into coin value, product selection or cancel
  always_comb begin
    is_coin   = 1'b0;
    is_sel    = 1'b0;
    is_cancel = 1'b0;
    coin_val  = 8'd0;
    sel_price = 8'd0;
    sel_prod  = 2'd0;
    case (key_value)
      4'h1: begin is_coin = 1'b1; coin_val = 8'd5;  end
      4'h2: begin is_coin = 1'b1; coin_val = 8'd10; end
      4'h3: begin is_coin = 1'b1; coin_val = 8'd25; end
      4'hA: begin is_sel = 1'b1; sel_price = 8'(PRICE_A); sel_prod = 2'd0; end
      4'hB: begin is_sel = 1'b1; sel_price = 8'(PRICE_B); sel_prod = 2'd1; end
      4'hC: begin is_sel = 1'b1; sel_price = 8'(PRICE_C); sel_prod = 2'd2; end
      4'hD: begin is_sel = 1'b1; sel_price = 8'(PRICE_D); sel_prod = 2'd3; end
      4'hE: is_cancel = 1'b1;
      default: ;
    endcase
  end

  // Credit arithmetic in 9 bits so the ceiling compare sees any overflow
  always_comb begin
    credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
    coin_ok    = (credit_sum <= CEILING);
    price_ok   = (credit_q >= sel_price);
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_d       = change_q;
    product_d      = product_q;
    cnt_d          = cnt_q;
    dispense_d     = 1'b0;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (key_valid) begin
          if (is_coin) begin
            if (coin_ok) begin
              credit_d = credit_sum[7:0];
              state_d  = ST_CREDIT;
            end else begin
              coin_reject_d = 1'b1;
            end
          end else if (is_sel) begin
            // IDLE always has zero credit, so a selection there is insufficient
            if ((state_q == ST_CREDIT) && price_ok) begin
              product_d  = sel_prod;
              change_d   = credit_q - sel_price;
              cnt_d      = '0;
              dispense_d = 1'b1;
              state_d    = ST_VEND;
            end else begin
              insufficient_d = 1'b1;
            end
          end else if (is_cancel && (state_q == ST_CREDIT)) begin
            change_d       = credit_q;
            cnt_d          = '0;
            change_valid_d = 1'b1;
            state_d        = ST_CHANGE;
          end
        end
      end

      ST_VEND: begin
        if (cnt_q == DISP_LAST) begin
          cnt_d = '0;
          if (change_q != 8'd0) begin
            change_valid_d = 1'b1;
            state_d        = ST_CHANGE;
          end else begin
            credit_d = 8'd0;
            state_d  = ST_IDLE;
          end
        end else begin
          cnt_d      = cnt_q + 1'b1;
          dispense_d = 1'b1;
        end
      end

      ST_CHANGE: begin
        if (cnt_q == CHG_LAST) begin
          cnt_d    = '0;
          credit_d = 8'd0;
          change_d = 8'd0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d          = cnt_q + 1'b1;
          change_valid_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  // State and output registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      credit_q       <= 8'd0;
      change_q       <= 8'd0;
      product_q      <= 2'd0;
      cnt_q          <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_q       <= change_d;
      product_q      <= product_d;
      cnt_q          <= cnt_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      busy_q         <= busy_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
    end
  end

  assign credit       = credit_q;
  assign change       = change_q;
  assign product      = product_q;
  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign busy         = busy_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vend_controller
//  Brief    : Self-checking bench for vend_controller. A transaction-level
//             model predicts output events into a queue; a monitor turns the
//             DUT's outputs into the same events and compares in order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

  localparam int PA = 25, PB = 50, PC = 75, PD = 100;
  localparam int MAXC = 250, DCYC = 4, CCYC = 8;

  localparam int EV_CRED = 0, EV_REJ = 1, EV_INS = 2, EV_DISP = 3, EV_CHG = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_value;
  logic       key_valid;
  logic [7:0] credit, change;
  logic [1:0] product;
  logic       dispense, change_valid, busy, coin_reject, insufficient;

  vend_controller #(
    .PRICE_A(PA), .PRICE_B(PB), .PRICE_C(PC), .PRICE_D(PD),
    .MAX_CREDIT(MAXC), .DISPENSE_CYCLES(DCYC), .CHANGE_CYCLES(CCYC)
  ) dut (
    .clk(clk), .reset(reset), .key_value(key_value), .key_valid(key_valid),
    .credit(credit), .change(change), .product(product), .dispense(dispense),
    .change_valid(change_valid), .busy(busy), .coin_reject(coin_reject),
    .insufficient(insufficient)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  bit  mon_en = 1'b0;

  // Transaction-level model state
  int model_credit  = 0;
  int model_product = 0;

  function automatic void push_ev(input int kind, input int a, input int b, input int c);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endfunction

  function automatic void check_ev(input int kind, input int a, input int b, input int c);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: actual kind=%0d a=%0d b=%0d c=%0d, required no event",
               kind, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b || e.c != c) begin
        bad++;
        $display("FAIL event_mismatch: actual kind=%0d a=%0d b=%0d c=%0d, required kind=%0d a=%0d b=%0d c=%0d",
                 kind, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endfunction

  function automatic void check_val(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Monitor: convert output activity into events, sampled on the falling edge
  int prev_credit = 0;
  int disp_len = 0, disp_prod = 0, disp_chg = 0;
  int chg_len = 0, chg_amt = 0;
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_credit = int'(credit);
      disp_len    = 0;
      chg_len     = 0;
    end else begin
      check_val("busy_vs_activity", int'(busy), int'(dispense | change_valid));
      if (dispense) begin
        disp_len++;
        disp_prod = int'(product);
        disp_chg  = int'(change);
      end else if (disp_len > 0) begin
        check_ev(EV_DISP, disp_prod, disp_chg, disp_len);
        disp_len = 0;
      end
      if (change_valid) begin
        chg_len++;
        chg_amt = int'(change);
      end else if (chg_len > 0) begin
        check_ev(EV_CHG, chg_amt, 0, chg_len);
        chg_len = 0;
      end
      if (coin_reject)  check_ev(EV_REJ, int'(credit), int'(product), 0);
      if (insufficient) check_ev(EV_INS, int'(credit), int'(product), 0);
      if (int'(credit) != prev_credit) check_ev(EV_CRED, int'(credit), int'(product), 0);
      prev_credit = int'(credit);
    end
  end

  // Apply one key; the model predicts its events, then any busy period is
  // filled with random strobes that must all be ignored.
  task automatic send_key(input logic [3:0] k, input int max_busy = -1);
    int dur = 0;
    int v   = 0;
    int p   = 0;
    int chg;
    int n;
    case (k)
      4'h1, 4'h2, 4'h3: begin
        v = (k == 4'h1) ? 5 : (k == 4'h2) ? 10 : 25;
        if (model_credit + v <= MAXC) begin
          model_credit += v;
          push_ev(EV_CRED, model_credit, model_product, 0);
        end else begin
          push_ev(EV_REJ, model_credit, model_product, 0);
        end
      end
      4'hA, 4'hB, 4'hC, 4'hD: begin
        p = (k == 4'hA) ? PA : (k == 4'hB) ? PB : (k == 4'hC) ? PC : PD;
        if (model_credit > 0 && model_credit >= p) begin
          chg = model_credit - p;
          model_product = int'(k) - 10;
          push_ev(EV_DISP, model_product, chg, DCYC);
          dur = DCYC;
          if (chg > 0) begin
            push_ev(EV_CHG, chg, 0, CCYC);
            dur += CCYC;
          end
          model_credit = 0;
          push_ev(EV_CRED, 0, model_product, 0);
        end else begin
          push_ev(EV_INS, model_credit, model_product, 0);
        end
      end
      4'hE: begin
        if (model_credit > 0) begin
          push_ev(EV_CHG, model_credit, 0, CCYC);
          model_credit = 0;
          push_ev(EV_CRED, 0, model_product, 0);
          dur = CCYC;
        end
      end
      default: ;
    endcase
    @(negedge clk);
    key_value = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    n = (max_busy >= 0 && max_busy < dur) ? max_busy : dur;
    for (int i = 0; i < n; i++) begin
      key_valid = 1'($urandom_range(0, 1));
      key_value = 4'($urandom);
      @(negedge clk);
    end
    key_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_credit"},       int'(credit), 0);
    check_val({tag, "_change"},       int'(change), 0);
    check_val({tag, "_product"},      int'(product), 0);
    check_val({tag, "_dispense"},     int'(dispense), 0);
    check_val({tag, "_change_valid"}, int'(change_valid), 0);
    check_val({tag, "_busy"},         int'(busy), 0);
    check_val({tag, "_coin_reject"},  int'(coin_reject), 0);
    check_val({tag, "_insufficient"}, int'(insufficient), 0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] rk;
  int         sel;

  initial begin
    reset     = 1'b0;
    key_value = 4'h0;
    key_valid = 1'b0;
    #1;
    check_all_zero("reset_initial");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2 mon_en = 1'b1;

    // Idle-state keys: cancel ignored, selection insufficient, junk codes ignored
    send_key(4'hE);
    send_key(4'hB);
    send_key(4'h0);
    send_key(4'hF);

    // Exact-payment vend of B
    send_key(4'h3); send_key(4'h3); send_key(4'hB);
    // Vend of A from 100 with 75 change
    repeat (4) send_key(4'h3);
    send_key(4'hA);
    // Credit ceiling boundary: 240 -> 245 -> reject -> 250 -> reject
    repeat (9) send_key(4'h3);
    send_key(4'h2); send_key(4'h1);
    send_key(4'h1); send_key(4'h2); send_key(4'h1); send_key(4'h1);
    send_key(4'h0); send_key(4'hF);
    send_key(4'hE);
    // Insufficient then cancel
    send_key(4'h2); send_key(4'hD); send_key(4'hE);

    // Reset in the middle of change return
    repeat (4) send_key(4'h3);
    send_key(4'hA, DCYC + 3);
    #2 mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check_all_zero("reset_in_change");
    exp_q.delete();
    model_credit  = 0;
    model_product = 0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2 mon_en = 1'b1;
    repeat (12) @(negedge clk);
    // First transaction after reset must time exactly
    send_key(4'h3); send_key(4'h2); send_key(4'h2); send_key(4'h3); send_key(4'hC);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 40)      rk = 4'($urandom_range(1, 3));
      else if (sel < 65) rk = 4'($urandom_range(10, 13));
      else if (sel < 72) rk = 4'hE;
      else begin
        rk = 4'($urandom);
        if (rk == 4'h0) rk = 4'h4;
      end
      send_key(rk);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        key_value = 4'($urandom);
      end
    end
    if (model_credit > 0) send_key(4'hE);
    repeat (20) @(negedge clk);

    check_val("leftover_expected_events", exp_q.size(), 0);
    check_val("final_busy", int'(busy), 0);
    check_val("final_credit", int'(credit), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
